// File: rtl/ahb_vtab.sv
// AHB-Lite slave holding a writable, lockable vector table (SP, RESET, NMI, FAULT, IRQn).
// Single outstanding data phase; OKAY completions take WAIT_STATES stalls, errors take two cycles.
module ahb_vtab #(
    parameter int NUM_IRQ     = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                        hclk,
    input  logic                        hreset,
    input  logic                        hsel,
    input  logic [1:0]                  htrans,
    input  logic [31:0]                 haddr,
    input  logic [2:0]                  hsize,
    input  logic                        hwrite,
    input  logic [31:0]                 hwdata,
    input  logic                        hready_in,
    input  logic [(NUM_IRQ+4)*32-1:0]   init_vec,
    output logic [31:0]                 hrdata,
    output logic                        hready,
    output logic                        hresp,
    output logic [(NUM_IRQ+4)*32-1:0]   vtab_out,
    output logic                        locked
);

    localparam int NUM_ENT = NUM_IRQ + 4;
    localparam int IDX_W   = $clog2(NUM_ENT);
    localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    // Handshake: a transfer is accepted on a rising edge where hsel & htrans[1] & hready_in;
    // its data phase completes in the first following cycle with hready=1, and hresp qualifies it.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t             state, state_nxt;
    logic [1:0]         cnt, cnt_nxt;
    logic               dp_valid, dp_valid_nxt;
    logic               dp_write;
    logic               dp_lock;
    logic [IDX_W-1:0]   dp_idx;
    logic               load_dp;
    logic [31:0]        vtab [NUM_ENT];

    logic               accept;
    logic [7:0]         off;
    logic [5:0]         irq_n;
    logic [7:0]         idx_full;
    logic               hit_core, hit_irq, hit_lock;
    logic               commit_now;
    logic               locked_eff;
    logic               acc_err;
    logic [31:0]        rd_word;
    logic               unused_bits;

    assign unused_bits = ^{haddr[31:16], htrans[0]};

    assign accept   = hsel & htrans[1] & hready_in;
    assign off      = haddr[7:0];
    assign irq_n    = off[7:2] - 6'd16;
    assign hit_core = (off[7:4] == 4'd0);
    // LOCK wins over IRQ47, which would otherwise alias to the same offset
    assign hit_lock = (off == 8'hFC);
    assign hit_irq  = (off >= 8'h40) && !hit_lock && ({2'b00, irq_n} < 8'(NUM_IRQ));
    assign idx_full = hit_core ? {6'b0, off[3:2]} : ({2'b00, irq_n} + 8'd4);

    assign commit_now = (state == S_IDLE) && dp_valid && dp_write;
    // A LOCK write completing on the same edge already locks the next accepted write
    assign locked_eff = locked | (commit_now & dp_lock & hwdata[0]);

    assign acc_err = (|haddr[15:8]) | (hsize != 3'b010) | (|haddr[1:0])
                   | !(hit_core | hit_irq | hit_lock)
                   | (hwrite & !hit_lock & locked_eff);

    // Writes commit before a following read's data phase, so a back-to-back read sees new data
    assign rd_word = dp_lock ? {31'b0, locked} : vtab[dp_idx];

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dp_valid_nxt = dp_valid;
        load_dp      = 1'b0;
        hready       = 1'b1;
        hresp        = 1'b0;
        case (state)
            S_IDLE, S_ERR2: begin
                hresp        = (state == S_ERR2);
                state_nxt    = S_IDLE;
                dp_valid_nxt = 1'b0;
                if (accept) begin
                    if (acc_err) begin
                        state_nxt = S_ERR1;
                    end else begin
                        load_dp      = 1'b1;
                        dp_valid_nxt = 1'b1;
                        if (WAIT_STATES != 0) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = WS_LOAD;
                        end
                    end
                end
            end
            S_WAIT: begin
                hready = 1'b0;
                if (cnt == 2'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            S_ERR1: begin
                hready    = 1'b0;
                hresp     = 1'b1;
                state_nxt = S_ERR2;
            end
            default: begin
                state_nxt    = S_IDLE;
                dp_valid_nxt = 1'b0;
            end
        endcase
        hrdata = ((state == S_IDLE) && dp_valid && !dp_write) ? rd_word : 32'h0;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= S_IDLE;
            cnt      <= 2'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_lock  <= 1'b0;
            dp_idx   <= '0;
            locked   <= 1'b0;
            for (int i = 0; i < NUM_ENT; i++) begin
                vtab[i] <= init_vec[i*32 +: 32];
            end
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dp_valid <= dp_valid_nxt;
            if (load_dp) begin
                dp_write <= hwrite;
                dp_lock  <= hit_lock;
                dp_idx   <= idx_full[IDX_W-1:0];
            end
            if (commit_now) begin
                if (dp_lock) begin
                    locked <= locked | hwdata[0];
                end else begin
                    vtab[dp_idx] <= hwdata;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_out
        assign vtab_out[g*32 +: 32] = vtab[g];
    end

endmodule

// File: tb/tb_ahb_vtab.sv
// Scoreboard bench for ahb_vtab: one instance with no wait states, one with two.
// Drivers push the expected response per transfer; a negedge monitor pops and compares.
module tb_ahb_vtab;

    localparam int NUM_IRQ = 16;
    localparam int VW      = (NUM_IRQ + 4) * 32;

    logic              hclk = 1'b0;
    logic              hreset;
    logic              hsel      [2];
    logic [1:0]        htrans    [2];
    logic [31:0]       haddr     [2];
    logic [2:0]        hsize     [2];
    logic              hwrite    [2];
    logic [31:0]       hwdata    [2];
    logic              hready_in [2];
    logic [VW-1:0]     init_vec;
    logic [31:0]       hrdata    [2];
    logic              hready    [2];
    logic              hresp     [2];
    logic [VW-1:0]     vtab_out  [2];
    logic              locked    [2];

    // expected entry: {waits[1:0], err, rdata[31:0]}
    logic [34:0] exp_q0[$];
    logic [34:0] exp_q1[$];

    int checks = 0;
    int errors = 0;
    bit pending [2];
    int stall   [2];
    bit bad     [2];

    ahb_vtab #(.NUM_IRQ(NUM_IRQ), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .htrans(htrans[0]),
        .haddr(haddr[0]), .hsize(hsize[0]), .hwrite(hwrite[0]), .hwdata(hwdata[0]),
        .hready_in(hready_in[0]), .init_vec(init_vec), .hrdata(hrdata[0]),
        .hready(hready[0]), .hresp(hresp[0]), .vtab_out(vtab_out[0]), .locked(locked[0])
    );

    ahb_vtab #(.NUM_IRQ(NUM_IRQ), .WAIT_STATES(2)) u_dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .htrans(htrans[1]),
        .haddr(haddr[1]), .hsize(hsize[1]), .hwrite(hwrite[1]), .hwdata(hwdata[1]),
        .hready_in(hready_in[1]), .init_vec(init_vec), .hrdata(hrdata[1]),
        .hready(hready[1]), .hresp(hresp[1]), .vtab_out(vtab_out[1]), .locked(locked[1])
    );

    assign hready_in[0] = hready[0];
    assign hready_in[1] = hready[1];

    // clock / reset
    always #5 hclk = ~hclk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic int q_size(int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [34:0] q_front(int d);
        return (d == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    function automatic logic [34:0] q_pop(int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // monitor
    task automatic mon_step(int d);
        logic [34:0] e;
        if (hreset) begin
            if (pending[d] && q_size(d) > 0) void'(q_pop(d));
            pending[d] = 0;
            stall[d]   = 0;
            bad[d]     = 0;
            return;
        end
        if (pending[d]) begin
            if (q_size(d) == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected transfer: no expected entry", d);
                pending[d] = 0;
            end else if (!hready[d]) begin
                e = q_front(d);
                stall[d]++;
                if (hresp[d] !== e[32] || hrdata[d] !== 32'h0) bad[d] = 1;
                if (stall[d] > 8) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d completion timeout: stalls %0d, expected %0d", d, stall[d], e[34:33]);
                    void'(q_pop(d));
                    pending[d] = 0;
                    stall[d]   = 0;
                    bad[d]     = 0;
                end
            end else begin
                e = q_pop(d);
                checks++;
                if (hresp[d] !== e[32] || hrdata[d] !== e[31:0] || stall[d] != int'(e[34:33]) || bad[d]) begin
                    errors++;
                    $display("FAIL dut%0d xfer: resp=%b rdata=%h stalls=%0d stall_ok=%b, expected resp=%b rdata=%h stalls=%0d",
                             d, hresp[d], hrdata[d], stall[d], !bad[d], e[32], e[31:0], e[34:33]);
                end
                pending[d] = 0;
                stall[d]   = 0;
                bad[d]     = 0;
            end
        end else begin
            checks++;
            if (hready[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL dut%0d idle bus: hready=%b hresp=%b hrdata=%h, expected 1 0 00000000",
                         d, hready[d], hresp[d], hrdata[d]);
            end
        end
        if (hsel[d] && htrans[d][1] && hready_in[d]) pending[d] = 1;
    endtask

    always @(negedge hclk) begin
        mon_step(0);
        mon_step(1);
    end

    // drivers
    task automatic xfer(int d, logic [15:0] addr, bit wr, logic [2:0] size,
                        logic [31:0] wdata, bit err, logic [31:0] rdata);
        int n;
        logic [1:0] w;
        w = err ? 2'd1 : ((d == 1) ? 2'd2 : 2'd0);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = {16'h0, addr};
        hwrite[d] = wr;
        hsize[d]  = size;
        if (d == 0) exp_q0.push_back({w, err, (err || wr) ? 32'h0 : rdata});
        else        exp_q1.push_back({w, err, (err || wr) ? 32'h0 : rdata});
        n = 0;
        @(negedge hclk);
        while (!hready[d] && n < 20) begin
            @(negedge hclk);
            n++;
        end
        if (!hready[d]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d accept timeout: hready=%b, expected 1", d, hready[d]);
        end
        @(posedge hclk);
        #1;
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        if (wr) hwdata[d] = wdata;
    endtask

    task automatic rd(int d, logic [15:0] addr, bit err, logic [31:0] rdata);
        xfer(d, addr, 1'b0, 3'b010, 32'h0, err, rdata);
    endtask

    task automatic wr(int d, logic [15:0] addr, logic [31:0] wdata, bit err);
        xfer(d, addr, 1'b1, 3'b010, wdata, err, 32'h0);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 0; htrans[d] = 0; haddr[d] = 0; hsize[d] = 0; hwrite[d] = 0; hwdata[d] = 0;
            pending[d] = 0; stall[d] = 0; bad[d] = 0;
        end
        init_vec[0*32 +: 32] = 32'h2000_0400;
        init_vec[1*32 +: 32] = 32'h0000_0101;
        init_vec[2*32 +: 32] = 32'h0000_0202;
        init_vec[3*32 +: 32] = 32'h0000_0303;
        for (int i = 4; i < NUM_IRQ + 4; i++) init_vec[i*32 +: 32] = 32'h1000_0000 + 32'(i - 4);

        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;

        // reset state
        @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset hready", d), {31'b0, hready[d]}, 32'd1);
            check($sformatf("dut%0d reset hresp", d), {31'b0, hresp[d]}, 32'd0);
            check($sformatf("dut%0d reset locked", d), {31'b0, locked[d]}, 32'd0);
            for (int i = 0; i < NUM_IRQ + 4; i++)
                check($sformatf("dut%0d reset word%0d", d, i), vtab_out[d][i*32 +: 32], init_vec[i*32 +: 32]);
        end
        @(posedge hclk);
        #1;

        // no wait states: reads, write/read forwarding, error cases
        rd(0, 16'h0004, 0, 32'h0000_0101);
        rd(0, 16'h0044, 0, 32'h1000_0001);
        rd(0, 16'h007C, 0, 32'h1000_000F);
        wr(0, 16'h0040, 32'hCAFE_0001, 0);
        rd(0, 16'h0040, 0, 32'hCAFE_0001);
        rd(0, 16'h0080, 1, 32'h0);
        rd(0, 16'h0010, 1, 32'h0);
        xfer(0, 16'h0000, 1'b0, 3'b000, 32'h0, 1, 32'h0);
        rd(0, 16'h0002, 1, 32'h0);
        rd(0, 16'h0100, 1, 32'h0);
        rd(0, 16'h00FC, 0, 32'h0);
        wr(0, 16'h00FC, 32'h0000_0000, 0);
        rd(0, 16'h00FC, 0, 32'h0);
        idle(2);

        // non-transfers: hsel low, then BUSY
        hsel[0] = 1'b0; htrans[0] = 2'b10; haddr[0] = 32'h4;
        @(negedge hclk);
        check("dut0 hsel0 hready", {31'b0, hready[0]}, 32'd1);
        @(posedge hclk); #1;
        hsel[0] = 1'b1; htrans[0] = 2'b01;
        @(negedge hclk);
        check("dut0 busy hresp", {31'b0, hresp[0]}, 32'd0);
        @(posedge hclk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00;
        @(negedge hclk);
        check("dut0 busy hrdata", hrdata[0], 32'h0);
        @(posedge hclk); #1;

        // locking
        wr(0, 16'h00FC, 32'h0000_0001, 0);
        idle(2);
        wr(0, 16'h0008, 32'h1234_5678, 1);
        rd(0, 16'h0008, 0, 32'h0000_0202);
        rd(0, 16'h00FC, 0, 32'h0000_0001);
        wr(0, 16'h00FC, 32'h0000_0001, 0);
        idle(3);
        check("dut0 locked", {31'b0, locked[0]}, 32'd1);
        check("dut0 nmi word", vtab_out[0][2*32 +: 32], 32'h0000_0202);
        check("dut0 irq0 word", vtab_out[0][4*32 +: 32], 32'hCAFE_0001);

        // two wait states
        wr(1, 16'h0040, 32'hDEAD_BEEF, 0);
        rd(1, 16'h0040, 0, 32'hDEAD_BEEF);
        idle(4);
        check("dut2 irq0 word", vtab_out[1][4*32 +: 32], 32'hDEAD_BEEF);
        rd(1, 16'h0080, 1, 32'h0);
        rd(1, 16'h0004, 0, 32'h0000_0101);
        idle(3);

        // reset during the wait of a FAULT write
        wr(1, 16'h000C, 32'h55AA_55AA, 0);
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("dut2 fault after abort", vtab_out[1][3*32 +: 32], 32'h0000_0303);
        check("dut2 irq0 after reset", vtab_out[1][4*32 +: 32], 32'h1000_0000);
        check("dut2 hready after reset", {31'b0, hready[1]}, 32'd1);
        check("dut2 locked after reset", {31'b0, locked[1]}, 32'd0);
        check("dut0 locked after reset", {31'b0, locked[0]}, 32'd0);
        @(posedge hclk); #1;
        rd(1, 16'h000C, 0, 32'h0000_0303);
        idle(5);

        check("dut0 queue drained", 32'(exp_q0.size()), 32'd0);
        check("dut2 queue drained", 32'(exp_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_vtab.md
AHB_VTAB -- requirements
Module: ahb_vtab

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16, meaning number of IRQ vector entries, legal range 1..48.
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning stall cycles inserted before each OKAY completion, legal range 0..3.
REQ-003 SHALL have port hclk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port hreset, input, 1, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port hsel, input, 1, meaning slave select.
REQ-006 SHALL have port htrans, input, 2, meaning AHB transfer type; only NONSEQ and SEQ (htrans[1]=1) are transfers.
REQ-007 SHALL have port haddr, input, 32, meaning transfer address.
REQ-008 SHALL have port hsize, input, 3, meaning transfer size.
REQ-009 SHALL have port hwrite, input, 1, meaning write when 1.
REQ-010 SHALL have port hwdata, input, 32, meaning write data, sampled in the data phase.
REQ-011 SHALL have port hready_in, input, 1, meaning bus-level ready.
REQ-012 SHALL have port init_vec, input, (NUM_IRQ+4)*32, meaning reset values: SP, RESET, NMI and FAULT in the low four words, then IRQ0 upward.
REQ-013 SHALL have port hrdata, output, 32, meaning read data.
REQ-014 SHALL have port hready, output, 1, meaning slave ready.
REQ-015 SHALL have port hresp, output, 1, meaning error response.
REQ-016 SHALL have port vtab_out, output, (NUM_IRQ+4)*32, meaning the live table contents, in the same packing as init_vec.
REQ-017 SHALL have port locked, output, 1, meaning the table is write-locked.

Function
REQ-018 SHALL accept a transfer when hsel & htrans[1] & hready_in are all 1, and SHALL capture haddr[15:0], hwrite and hsize at that edge.
REQ-019 SHALL use this map: 0x00 SP, 0x04 RESET, 0x08 NMI, 0x0C FAULT, 0x40+4n IRQn for n<NUM_IRQ, 0xFC LOCK.
REQ-020 SHALL flag an error when any of these holds: haddr[15:8]!=0; hsize!=3'b010; haddr[1:0]!=0; the offset is unmapped (this includes IRQn with n>=NUM_IRQ); or it is a write to any entry other than LOCK while locked=1.
REQ-021 SHALL give an error as a two-cycle response: first cycle hready=0, hresp=1; second cycle hready=1, hresp=1. WAIT_STATES is not applied, and the table is unchanged.
REQ-022 SHALL complete an OKAY transfer after exactly WAIT_STATES data-phase cycles with hready=0, hresp=0, followed by one cycle with hready=1, hresp=0.
REQ-023 SHALL implement a state machine with states IDLE, WAIT (counts down WAIT_STATES), ERR1 and ERR2. Transitions: IDLE->WAIT or IDLE->ERR1 on accept; WAIT->IDLE when the count expires; ERR1->ERR2; ERR2->IDLE.
REQ-024 SHALL accept a back-to-back transfer in any cycle where hready=1, including the final cycle of an OKAY completion and ERR2.
REQ-025 SHALL drive hrdata with the addressed word only in the completing cycle of an OKAY read; in all other cycles it SHALL be 0.
REQ-026 SHALL return {31'b0, locked} for a read of LOCK.
REQ-027 SHALL commit a write at the rising edge that ends its completing (hready=1) cycle, using hwdata.
REQ-028 SHALL, on a write to LOCK with hwdata[0]=1, set locked; a write with hwdata[0]=0 SHALL be ignored (OKAY response). locked SHALL be sticky until reset.
REQ-029 SHALL forward write data when a read targets the entry being written by the immediately preceding write, so that the read returns the new value.
REQ-030 SHALL update vtab_out in the cycle after a write commits.
REQ-031 SHALL treat IDLE or BUSY htrans, and hsel=0, as no transfer: hready=1, hresp=0, no state change.

Reset
REQ-032 SHALL, when hreset=1 at a rising edge, load every entry from init_vec, clear locked, set hrdata=0, hready=1, hresp=0, and enter IDLE.
REQ-033 SHALL abort any transfer in progress when hreset is asserted mid-transfer; no write commits on that edge.

Verification
REQ-034 SHALL be checked by: reset with init_vec word1=0x0000_0101, then read 0x04 with WAIT_STATES=0 -> next cycle hready=1, hresp=0, hrdata=0x0000_0101.
REQ-035 SHALL be checked by: WAIT_STATES=2, write 0x40 with 0xDEAD_BEEF then read 0x40 back-to-back -> each transfer shows 2 cycles hready=0 then completes; the read returns 0xDEAD_BEEF; vtab_out word4=0xDEAD_BEEF.
REQ-036 SHALL be checked by: with NUM_IRQ=16, read 0x80; then read 0x10; then a byte read of 0x00 -> each gives ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), and hrdata=0.
REQ-037 SHALL be checked by: write LOCK=1, then write 0x08 with 0x1234_5678 -> the second write gets an error response and NMI keeps its init value; a LOCK read returns 0x1; locked=1.
REQ-038 SHALL be checked by: assert hreset during the WAIT state of a write to 0x0C -> FAULT equals its init_vec word3, hready=1, and locked=0 after reset.
